// File: rtl/branch_history_table_pkg.sv
// Shared constants and counter encodings for the branch pattern history table.
// The 2-bit counter meaning: 0x = predict fall-through, 1x = predict taken.
package branch_history_table_pkg;

    localparam int ADDR_SIZE      = 32;
    localparam int BHT_INDEX_BITS = 6;

    typedef enum logic [1:0] {
        STATE_SNT = 2'b00,
        STATE_WNT = 2'b01,
        STATE_WT  = 2'b10,
        STATE_ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_INIT_STATE = STATE_WNT;

endpackage

// File: rtl/branch_history_table_sat_counter2.sv
// Next-state function of a 2-bit saturating counter, shared by the array write
// and the read bypass so the two can never disagree.
module sat_counter2
    import branch_history_table_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != STATE_ST) begin
                nxt = cur + 2'd1;
            end
        end else begin
            if (cur != STATE_SNT) begin
                nxt = cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Untagged pattern history table of 2-bit counters indexed by pc[INDEX_BITS+1:2],
// with a same-cycle update bypass and saturating branch/mispredict statistics.
module branch_history_table
    import branch_history_table_pkg::*;
#(
    parameter int INDEX_BITS = BHT_INDEX_BITS,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_SIZE-1:0]  rd_pc,
    output logic [1:0]            rd_state,
    input  logic                  upd_valid,
    input  logic [ADDR_SIZE-1:0]  upd_pc,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    // Update handshake: upd_valid has no ready; every cycle with upd_valid high
    // (and rstn high) is accepted and applied exactly once at that rising edge.

    // Flop array rather than RAM so every entry can be reset in one cycle.
    logic [1:0]            table_q [ENTRIES];
    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_nxt;
    logic                  unused_pc_bits;

    assign rd_idx  = rd_pc[INDEX_BITS+1:2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_cur = table_q[upd_idx];

    assign unused_pc_bits = ^{rd_pc[ADDR_SIZE-1:INDEX_BITS+2], rd_pc[1:0],
                              upd_pc[ADDR_SIZE-1:INDEX_BITS+2], upd_pc[1:0]};

    sat_counter2 u_upd_counter (
        .cur   (upd_cur),
        .taken (upd_taken),
        .nxt   (upd_nxt)
    );

    always_comb begin
        rd_state = STATE_SNT;
        if (rstn) begin
            if (upd_valid && (upd_idx == rd_idx)) begin
                rd_state = upd_nxt;
            end else begin
                rd_state = table_q[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= BHT_INIT_STATE;
            end
        end else if (upd_valid) begin
            table_q[upd_idx] <= upd_nxt;
        end
    end

    // Statistics saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            if (stat_branches != STAT_MAX) begin
                stat_branches <= stat_branches + STAT_WIDTH'(1);
            end
            if (upd_mispredict && (stat_mispredicts != STAT_MAX)) begin
                stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table: the driver queues expected values,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_branch_history_table;
    import branch_history_table_pkg::*;

    localparam int K_RD     = 0;
    localparam int K_BR     = 1;
    localparam int K_MIS    = 2;
    localparam int K_NBR    = 3;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rstn;
    logic [ADDR_SIZE-1:0] rd_pc;
    logic [ADDR_SIZE-1:0] upd_pc;
    logic                 upd_valid;
    logic                 upd_taken;
    logic                 upd_mispredict;
    logic [1:0]           rd_state;
    logic [1:0]           rd_state_n;
    logic [31:0]          stat_branches;
    logic [31:0]          stat_mispredicts;
    logic [3:0]           stat_branches_n;
    logic [3:0]           stat_mispredicts_n;

    branch_history_table #(.INDEX_BITS(6), .STAT_WIDTH(32)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .rd_pc            (rd_pc),
        .rd_state         (rd_state),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    branch_history_table #(.INDEX_BITS(6), .STAT_WIDTH(4)) dut_narrow (
        .clk              (clk),
        .rstn             (rstn),
        .rd_pc            (rd_pc),
        .rd_state         (rd_state_n),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (stat_branches_n),
        .stat_mispredicts (stat_mispredicts_n)
    );

    // scoreboard
    logic [31:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic expect_val(input int kind, input logic [31:0] val, input string name);
        kind_q.push_back(kind);
        exp_q.push_back(val);
        name_q.push_back(name);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [31:0] exp_v;
            logic [31:0] act_v;
            int          kind;
            string       name;
            exp_v = exp_q.pop_front();
            kind  = kind_q.pop_front();
            name  = name_q.pop_front();
            case (kind)
                K_RD:    act_v = {30'd0, rd_state};
                K_BR:    act_v = stat_branches;
                K_MIS:   act_v = stat_mispredicts;
                default: act_v = {28'd0, stat_branches_n};
            endcase
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act_v, exp_v, $time);
            end
        end
    end

    // driver tasks
    task automatic drive(input logic rn, input logic [31:0] rpc, input logic v,
                         input logic [31:0] upc, input logic t, input logic m);
        rstn           = rn;
        rd_pc          = rpc;
        upd_valid      = v;
        upd_pc         = upc;
        upd_taken      = t;
        upd_mispredict = m;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] up_exp[3];
        logic [1:0] dn_exp[4];
        logic       mis_pat[5];
        up_exp  = '{2'b10, 2'b11, 2'b11};
        dn_exp  = '{2'b10, 2'b01, 2'b00, 2'b00};
        mis_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // reset with an update presented: read forced to 00, update discarded
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0);
        expect_val(K_RD, 32'd0, "rst_rd_zero");
        tick; tick; tick;

        drive(1'b1, 32'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_val(K_RD, 32'd1, "idle_rd_00");
        expect_val(K_BR, 32'd0, "idle_stat_br");
        expect_val(K_MIS, 32'd0, "idle_stat_mis");
        expect_val(K_NBR, 32'd0, "idle_narrow_br");
        tick;
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_val(K_RD, 32'd1, "idle_rd_40");
        tick;
        drive(1'b1, 32'hFC, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_val(K_RD, 32'd1, "idle_rd_fc");
        tick;

        // saturate up on 0x100 (read 0x40 during updates to avoid bypass)
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
            tick;
            drive(1'b1, 32'h100, 1'b0, 32'h100, 1'b0, 1'b0);
            expect_val(K_RD, {30'd0, up_exp[i]}, $sformatf("sat_up_%0d", i));
            tick;
        end
        drive(1'b1, 32'h100, 1'b0, 32'h100, 1'b0, 1'b0);
        expect_val(K_BR, 32'd3, "sat_up_stat_br");
        tick;

        // saturate down
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
            tick;
            drive(1'b1, 32'h100, 1'b0, 32'h100, 1'b0, 1'b0);
            expect_val(K_RD, {30'd0, dn_exp[i]}, $sformatf("sat_dn_%0d", i));
            tick;
        end
        drive(1'b1, 32'h100, 1'b0, 32'h100, 1'b0, 1'b0);
        expect_val(K_BR, 32'd7, "sat_dn_stat_br");
        tick;

        // bypass and aliasing from a fresh table
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0);
        expect_val(K_RD, 32'd2, "bypass_rd");
        expect_val(K_BR, 32'd0, "bypass_pre_stat_br");
        tick;
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_val(K_RD, 32'd2, "alias_rd_300");
        tick;
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_val(K_RD, 32'd1, "no_alias_rd_40");
        tick;

        // mispredict statistics
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, mis_pat[i]);
            if (i == 1) begin
                expect_val(K_BR, 32'd1, "mis_step_br");
                expect_val(K_MIS, 32'd1, "mis_step_mis");
            end
            tick;
        end
        drive(1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 1'b1);
        expect_val(K_BR, 32'd5, "mis_stat_br");
        expect_val(K_MIS, 32'd3, "mis_stat_mis");
        tick;
        drive(1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 1'b1);
        expect_val(K_BR, 32'd5, "mis_novalid_br");
        expect_val(K_MIS, 32'd3, "mis_novalid_mis");
        tick;

        // reset mid-operation overrides a concurrent update
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
            tick;
        end
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_val(K_RD, 32'd3, "pre_rst_rd");
        expect_val(K_BR, 32'd7, "pre_rst_stat_br");
        tick;
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1);
        expect_val(K_RD, 32'd0, "mid_rst_rd");
        tick;
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_val(K_RD, 32'd1, "post_rst_rd");
        expect_val(K_BR, 32'd0, "post_rst_stat_br");
        expect_val(K_MIS, 32'd0, "post_rst_stat_mis");
        tick;

        // stat saturation on the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 1'b0);
            tick;
        end
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_val(K_BR, 32'd17, "wide_stat_br_17");
        expect_val(K_NBR, 32'd15, "narrow_stat_sat");
        tick;
        tick;

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d checks left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
